// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the parametrised serial-pattern detector.
package seq_det_pkg;

    // FILL: fewer than PATTERN_W valid bits collected; ARMED: every valid bit is compared.
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } seq_det_state_t;

    localparam int SEQ_DET_PATTERN_W = 4;
    localparam int SEQ_DET_CNT_W     = 8;

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial stream / configuration / detection bundle for seq_detector_param.
// Counter clear and count signals exist only when SEQ_DET_CNT_EN is defined.
interface seq_detector_param_if
    import seq_det_pkg::*;
#(
    parameter int PATTERN_W = SEQ_DET_PATTERN_W,
    parameter int CNT_W     = SEQ_DET_CNT_W
);

    logic                 seq_valid_i;
    logic                 seq_i;
    logic                 overlap_i;
    logic                 cfg_load_i;
    logic [PATTERN_W-1:0] pattern_i;
    logic                 det_o;

`ifdef SEQ_DET_CNT_EN
    logic                 cnt_clr_i;
    logic [CNT_W-1:0]     det_cnt_o;

    modport master (
        output seq_valid_i, seq_i, overlap_i, cfg_load_i, pattern_i, cnt_clr_i,
        input  det_o, det_cnt_o
    );

    modport slave (
        input  seq_valid_i, seq_i, overlap_i, cfg_load_i, pattern_i, cnt_clr_i,
        output det_o, det_cnt_o
    );
`else
    // Keeps the width parameter referenced in the counter-less build.
    logic [31:0] unused_cnt_w;
    assign unused_cnt_w = 32'(CNT_W);

    modport master (
        output seq_valid_i, seq_i, overlap_i, cfg_load_i, pattern_i,
        input  det_o
    );

    modport slave (
        input  seq_valid_i, seq_i, overlap_i, cfg_load_i, pattern_i,
        output det_o
    );
`endif

endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_reg;

    // Count increments, stick at all-ones, clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial-pattern detector: compares the last PATTERN_W valid bits
// against a runtime-loadable pattern and pulses det_o one cycle after a match.
// Optional feature macro: SEQ_DET_CNT_EN adds a saturating detection counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W    = SEQ_DET_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN_INIT = PATTERN_W'(4'b1011),
    parameter int                   CNT_W        = SEQ_DET_CNT_W
) (
    input logic                clk_i,
    input logic                rst_i,
    seq_detector_param_if.slave bus
);

    localparam int                FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_W - 1);

    seq_det_state_t       state_reg;
    logic [PATTERN_W-1:0] pat_q;
    logic [PATTERN_W-1:0] hist_q;
    logic [FILL_W-1:0]    fill_q;
    logic                 det_reg;

    logic [PATTERN_W-1:0] hist_next;
    logic                 match_next;

    // The bit arriving now completes a full window either when already armed or
    // when it is the PATTERN_W-th bit of the fill phase.
    assign hist_next  = {hist_q[PATTERN_W-2:0], bus.seq_i};
    assign match_next = bus.seq_valid_i && !bus.cfg_load_i &&
                        ((state_reg == ARMED) || (fill_q == FILL_LAST)) &&
                        (hist_next == pat_q);

    // Detector FSM: load restarts collection, valid bits shift/fill, matches pulse det.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= FILL;
            pat_q     <= PATTERN_INIT;
            hist_q    <= '0;
            fill_q    <= '0;
            det_reg   <= 1'b0;
        end else if (bus.cfg_load_i) begin
            state_reg <= FILL;
            pat_q     <= bus.pattern_i;
            hist_q    <= '0;
            fill_q    <= '0;
            det_reg   <= 1'b0;
        end else if (bus.seq_valid_i) begin
            hist_q  <= hist_next;
            det_reg <= match_next;
            if (match_next && !bus.overlap_i) begin
                // Non-overlapping: the next match needs a completely fresh window.
                state_reg <= FILL;
                fill_q    <= '0;
            end else begin
                case (state_reg)
                    FILL: begin
                        fill_q <= fill_q + 1'b1;
                        if (fill_q == FILL_LAST) begin
                            state_reg <= ARMED;
                        end
                    end
                    default: begin
                        state_reg <= ARMED;
                    end
                endcase
            end
        end else begin
            det_reg <= 1'b0;
        end
    end

    assign bus.det_o = det_reg;

`ifdef SEQ_DET_CNT_EN
    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (bus.cnt_clr_i),
        .inc (match_next),
        .cnt (bus.det_cnt_o)
    );
`else
    // Keeps the width parameter referenced in the counter-less build.
    logic [31:0] unused_cnt_w;
    assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: the driver pushes the expected
// response of a queue-based reference model for every clock edge, and a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_seq_detector_param;

    localparam int             PW   = 4;
    localparam int             CW   = 2;
    localparam logic [PW-1:0]  INIT = 4'b1011;
    localparam int             CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          det;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_detector_param_if #(.PATTERN_W(PW), .CNT_W(CW)) bus();

    seq_detector_param #(
        .PATTERN_W    (PW),
        .PATTERN_INIT (INIT),
        .CNT_W        (CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      n_txn    = 0;
    int      det_seen = 0;
    exp_t    exp_q[$];

    // Reference model: the valid bits received since the last reset, load or
    // non-overlapping detection, oldest first, trimmed to the window length.
    bit            m_bits[$];
    logic [PW-1:0] m_pat;
    int            m_cnt;

    function automatic bit model_match();
        if (m_bits.size() != PW) return 1'b0;
        for (int i = 0; i < PW; i++) begin
            if (m_bits[i] != m_pat[PW-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus plus the model's expectation for that edge.
    task automatic step(input bit v, input bit b, input bit ld, input logic [PW-1:0] p,
                        input bit clr, input bit ovl);
        bit d;
        bus.seq_valid_i = v;
        bus.seq_i       = b;
        bus.cfg_load_i  = ld;
        bus.pattern_i   = p;
        bus.overlap_i   = ovl;
`ifdef SEQ_DET_CNT_EN
        bus.cnt_clr_i   = clr;
`endif
        @(posedge clk);
        d = 1'b0;
        if (ld) begin
            m_pat = p;
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() > PW) void'(m_bits.pop_front());
            if (model_match()) begin
                d = 1'b1;
                if (!ovl) m_bits.delete();
            end
        end
        if (clr) m_cnt = 0;
        else if (d && m_cnt < CMAX) m_cnt++;
        exp_q.push_back('{det: d, cnt: CW'(m_cnt)});
        #1;
    endtask

    task automatic stream(input logic [31:0] bits, input int n, input bit ovl);
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[n-1-i], 1'b0, '0, 1'b0, ovl);
        end
    endtask

    // Let the monitor consume the last expectation before reading DUT state directly.
    task automatic drain();
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: one comparison per edge the driver modelled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                check("det_o", bus.det_o, e.det);
                if (bus.det_o === 1'b1) det_seen++;
`ifdef SEQ_DET_CNT_EN
                check("det_cnt_o", bus.det_cnt_o, e.cnt);
                $display("txn %0d: det_o=%0b exp=%0b det_cnt_o=%0d exp=%0d",
                         n_txn, bus.det_o, e.det, bus.det_cnt_o, e.cnt);
`else
                $display("txn %0d: det_o=%0b exp=%0b", n_txn, bus.det_o, e.det);
`endif
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.seq_valid_i = 1'b0;
        bus.seq_i       = 1'b0;
        bus.overlap_i   = 1'b0;
        bus.cfg_load_i  = 1'b0;
        bus.pattern_i   = '0;
`ifdef SEQ_DET_CNT_EN
        bus.cnt_clr_i   = 1'b0;
`endif
        m_pat = INIT;
        m_cnt = 0;

        // Reset state
        #2;
        check("reset_det_o", bus.det_o, 0);
`ifdef SEQ_DET_CNT_EN
        check("reset_det_cnt_o", bus.det_cnt_o, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Overlapping 1,0,1,1,0,1,1 against reset pattern 1011: two pulses
        base = det_seen;
        stream(32'b1011011, 7, 1'b1);
        drain();
        check("overlap_pulses", det_seen - base, 2);
`ifdef SEQ_DET_CNT_EN
        check("overlap_cnt", bus.det_cnt_o, 2);
`endif

        // Non-overlapping, same stream: one pulse
        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
        base = det_seen;
        stream(32'b1011011, 7, 1'b0);
        drain();
        check("nonoverlap_pulses", det_seen - base, 1);
`ifdef SEQ_DET_CNT_EN
        check("nonoverlap_cnt", bus.det_cnt_o, 1);
`endif

        // Gaps of invalid cycles between bits 2 and 3: one pulse
        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
        base = det_seen;
        stream(32'b10, 2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        stream(32'b11, 2, 1'b1);
        drain();
        check("gap_pulses", det_seen - base, 1);

        // Pattern load mid-stream discards the partial history
        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
        base = det_seen;
        stream(32'b101, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b1);
        stream(32'b0110, 4, 1'b1);
        drain();
        check("load_pulses", det_seen - base, 1);

        // Asynchronous reset after 1,0,1 then a final 1: no pulse
        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
        base = det_seen;
        stream(32'b101, 3, 1'b1);
        drain();
`ifdef SEQ_DET_CNT_EN
        check("cnt_before_rst", bus.det_cnt_o, 2);
`endif
        rst = 1'b1;
        bus.seq_valid_i = 1'b1;
        bus.seq_i       = 1'b1;
        #1;
        check("async_rst_det_o", bus.det_o, 0);
`ifdef SEQ_DET_CNT_EN
        check("async_rst_det_cnt_o", bus.det_cnt_o, 0);
`endif
        m_bits.delete();
        m_pat = INIT;
        m_cnt = 0;
        @(posedge clk);
        #1;
        check("held_rst_det_o", bus.det_o, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        drain();
        check("post_rst_pulses", det_seen - base, 0);

        // Saturation: five overlapping all-ones detections, then clear with a detection
        step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
        base = det_seen;
        stream(32'hFF, 8, 1'b1);
        drain();
        check("sat_pulses", det_seen - base, 5);
`ifdef SEQ_DET_CNT_EN
        check("sat_cnt", bus.det_cnt_o, CMAX);
`endif
        base = det_seen;
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        drain();
        check("clr_pulse", det_seen - base, 1);
`ifdef SEQ_DET_CNT_EN
        check("clr_wins_cnt", bus.det_cnt_o, 0);
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 70,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 4,
                 PW'($urandom),
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 60);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
